inv_pi_permute: RTL and testbench
=================================

# inv_pi_permute

Sequential inverse-pi lane permuter for the 5x5 bit state plane. The forward datapath moves the bit at (i,j) to (j, (2i+3j) mod 5). This block undoes that move, so it can restore a plane or check the forward result. It loads a 25-bit line, rebuilds the plane one bit per cycle with internal i/j counters, then reports completion with a start/done handshake. Flat indexing matches the forward datapath: index = 5*i + j.

## Interface
- SIZE, 5, row/column count. Only 5 is supported.
- MEMSIZE, 25, plane width (SIZE*SIZE). Only 25 is supported.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a permutation; sampled only in IDLE.
- line  input  MEMSIZE  plane to be permuted; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse (DONE state).
- mem  output  MEMSIZE  destination plane; holds the last result until the next accepted start.

## Operation
- Internal state:
  - src register (25 b), loaded from line.
  - dst register (25 b), drives mem.
  - 3-bit counters i and j.
  - FSM with states IDLE, RUN, DONE.
- IDLE, start=1 on an edge:
  - src<=line, dst<=0, i<=0, j<=0.
  - state<=RUN.
- IDLE, start=0: hold.
- RUN, each edge:
  - dst[5*i+j] <= src[5*j + ((2*i+3*j) mod 5)].
  - Then advance: j increments; at j=4, j<=0 and i increments.
  - On the edge that writes (i,j)=(4,4), state<=DONE and the counters return to 0.
- DONE: one cycle, then state<=IDLE unconditionally.
- start asserted during RUN or DONE is ignored. It is not queued; it must be held or re-asserted in IDLE.
- Arithmetic:
  - (2i+3j) mod 5 is computed on 5-bit unsigned values; the maximum pre-mod value is 20.
  - The mod is a compare-subtract chain or a lookup, with no divider.
  - Source index = 5*j + k is computed as (j<<2)+j+k, max 24.
- i and j never exceed 4 and never wrap beyond the (4,4) terminal step.
- Reset, at any time including mid-RUN:
  - state=IDLE.
  - src=0, dst=0, i=0, j=0.
  - busy=0, done=0, mem=0.
  - A partial result is discarded and no done is produced.
- line changes after the accepting edge have no effect on the running job.

## Timing
- Outputs are registered or state-decoded with no combinational path from start or line. busy=(state==RUN); done=(state==DONE).
- Let E0 be the edge where start is accepted:
  - busy rises after E0.
  - Edges E1..E25 perform the 25 bit writes.
  - done is high for exactly the cycle after E25.
  - busy falls after E25.
- Latency:
  - Start to done is 26 cycles.
  - Start to next acceptance is 27 cycles minimum, because start is first sampled in IDLE at E27.
- mem is valid when done=1 and stays stable until the edge after the next accepted start, which clears dst.
- mem is updated bit-by-bit during RUN; intermediate values are not meaningful.

## Test plan
- Reset, then line=25'h1, start for 1 cycle:
  - busy is high for 25 cycles.
  - done pulses once at 26 cycles.
  - mem=25'h0000001.
- line=25'h0000002 (bit 1) -> mem=25'h0008000 (bit 15; forward moves (3,0) to index 1).
- line=25'h0000020 (bit 5) -> mem=25'h0000040 (bit 6).
- line=25'h1000000 (bit 24) -> mem=25'h0000200 (bit 9).
- line=25'h1FFFFFF -> mem=25'h1FFFFFF.
- Random round trip, 200 random planes: apply the forward pi mapping in the model, feed the result in, and require mem equals the original plane.
- Robustness:
  - Pulse start again at RUN cycle 10: no effect, single done.
  - Change line during RUN: no effect.
  - Assert rst at RUN cycle 12: mem=0, busy=0, and no done appears.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/inv_pi_permute.sv
// Sequential inverse-pi permuter for a 5x5 bit plane: rebuilds dst one bit per
// cycle from the captured src plane, walking (i,j) in row-major order.
module inv_pi_permute #(
    parameter int SIZE    = 5,
    parameter int MEMSIZE = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MEMSIZE-1:0] line,
    output logic               busy,
    output logic               done,
    output logic [MEMSIZE-1:0] mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [MEMSIZE-1:0] src_q;
    logic [MEMSIZE-1:0] dst_q;
    logic [2:0]         i_q;
    logic [2:0]         j_q;
    logic               busy_q;
    logic               done_q;

    logic [4:0] i_ext;
    logic [4:0] j_ext;
    logic [4:0] sum_d;
    logic [4:0] k_d;
    logic [4:0] src_idx_d;
    logic [4:0] dst_idx_d;

    // Destination (i,j) pulls from source (j, (2i+3j) mod 5); mod by compare-subtract.
    always_comb begin
        i_ext = {2'b00, i_q};
        j_ext = {2'b00, j_q};
        sum_d = (i_ext << 1) + (j_ext << 1) + j_ext;
        k_d   = sum_d;
        if (sum_d >= 5'd20) begin
            k_d = sum_d - 5'd20;
        end else if (sum_d >= 5'd15) begin
            k_d = sum_d - 5'd15;
        end else if (sum_d >= 5'd10) begin
            k_d = sum_d - 5'd10;
        end else if (sum_d >= 5'd5) begin
            k_d = sum_d - 5'd5;
        end
        src_idx_d = (j_ext << 2) + j_ext + k_d;
        dst_idx_d = (i_ext << 2) + i_ext + j_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= line;
                        dst_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    dst_q[dst_idx_d] <= src_q[src_idx_d];
                    if (j_q == 3'(SIZE - 1)) begin
                        j_q <= '0;
                        if (i_q == 3'(SIZE - 1)) begin
                            i_q     <= '0;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            i_q <= i_q + 3'd1;
                        end
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign mem  = dst_q;

endmodule

// File: tb/tb_inv_pi_permute.sv
// Scoreboard bench for inv_pi_permute: expected planes queued at start, checked at done.
module tb_inv_pi_permute;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] line;
    logic        busy;
    logic        done;
    logic [24:0] mem;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [24:0] exp_q[$];

    inv_pi_permute #(.SIZE(5), .MEMSIZE(25)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .line (line),
        .busy (busy),
        .done (done),
        .mem  (mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Forward pi: bit (i,j) moves to (j, (2i+3j) mod 5).
    function automatic logic [24:0] fwd_pi(input logic [24:0] p);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[5*j + (2*i + 3*j) % 5] = p[5*i + j];
        return r;
    endfunction

    // mode 0: plain, 1: extra start pulse mid-run, 2: line changed mid-run
    task automatic run_job(input logic [24:0] pl, input logic [24:0] expect_mem, input int mode,
                           input bit full);
        int          n;
        int          busy_cnt;
        int          done_n;
        int          extra_done;
        logic [24:0] e;
        @(negedge clk);
        line  = pl;
        start = 1'b1;
        exp_q.push_back(expect_mem);
        @(negedge clk);
        start    = 1'b0;
        n        = 1;
        busy_cnt = 0;
        done_n   = 0;
        while (done_n == 0 && n < 60) begin
            if (busy) busy_cnt++;
            if (done) done_n = n;
            if (mode == 1 && n == 10) start = 1'b1;
            if (mode == 1 && n == 11) start = 1'b0;
            if (mode == 2 && n == 5) line = ~pl;
            if (done_n == 0) begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", 32'(done_n != 0), 32'd1);
        e = exp_q.pop_front();
        chk("mem", 32'(mem), 32'(e));
        if (full) begin
            chk("busy_cycles", busy_cnt, 25);
            chk("done_latency", done_n, 26);
        end
        extra_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        if (full) begin
            chk("single_done", extra_done, 0);
            chk("mem_hold", 32'(mem), 32'(e));
        end
    endtask

    initial begin
        logic [24:0] orig;
        int          done_cnt;
        rst   = 1'b1;
        start = 1'b0;
        line  = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem", 32'(mem), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_job(25'h0000001, 25'h0000001, 0, 1'b1);
        run_job(25'h0000002, 25'h0008000, 0, 1'b1);
        run_job(25'h0000020, 25'h0000040, 0, 1'b1);
        run_job(25'h1000000, 25'h0000200, 0, 1'b1);
        run_job(25'h1FFFFFF, 25'h1FFFFFF, 0, 1'b1);

        for (int t = 0; t < 200; t++) begin
            orig = 25'($urandom);
            run_job(fwd_pi(orig), orig, 0, 1'b0);
        end

        orig = 25'h0ABCDEF;
        run_job(fwd_pi(orig), orig, 1, 1'b1);
        orig = 25'h1234567;
        run_job(fwd_pi(orig), orig, 2, 1'b1);

        // Reset in the middle of a run: partial result dropped, no done.
        @(negedge clk);
        line  = 25'h1FFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_mem", 32'(mem), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_mem_after", 32'(mem), 32'd0);

        orig = 25'h15A5A5A;
        run_job(fwd_pi(orig), orig, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
